// File: rtl/sser_resp_tx.sv
// Serial responder transmitter: CPU-fed FIFO whose head word is shifted out LSB first
// on tx, one bit per falling edge of the initiator's cl while cs frames the transfer.
module sser_resp_tx #(
  parameter int          DW   = 8,
  parameter int          AW   = 2,
  parameter logic [DW-1:0] IDLE = '1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic          wready,
  input  logic          cs,
  input  logic          cl,
  output logic          tx,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          irq,
  output logic          underrun,
  output logic          aborted,
  input  logic          clr
);

  localparam int              BW    = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0]   LAST  = BW'(DW - 1);
  localparam logic [AW:0]     DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  sh_q, sh_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           irq_q, irq_d;
  logic           ur_q, ur_d;
  logic           ab_q, ab_d;
  logic [AW:0]    wptr_q, rptr_q;
  logic [DW-1:0]  mem [2**AW];

  logic cs_s1_q, cs_s2_q, cs_h_q;
  logic cl_s1_q, cl_s2_q, cl_h_q;
  logic cs_rise, cs_fall, cl_rise, cl_fall;
  logic push, pop, set_ur, set_ab, empty, full;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cs_s1_q <= 1'b0; cs_s2_q <= 1'b0; cs_h_q <= 1'b0;
      cl_s1_q <= 1'b0; cl_s2_q <= 1'b0; cl_h_q <= 1'b0;
    end else begin
      cs_s1_q <= cs;      cs_s2_q <= cs_s1_q; cs_h_q <= cs_s2_q;
      cl_s1_q <= cl;      cl_s2_q <= cl_s1_q; cl_h_q <= cl_s2_q;
    end
  end

  // cl edges are qualified by the cs history flop so that a final cl rise
  // coinciding with the cs fall still completes the frame.
  assign cs_rise = cs_s2_q & ~cs_h_q;
  assign cs_fall = ~cs_s2_q & cs_h_q;
  assign cl_rise = cl_s2_q & ~cl_h_q & cs_h_q;
  assign cl_fall = ~cl_s2_q & cl_h_q & cs_h_q;

  assign count  = wptr_q - rptr_q;
  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign wready = ~full;
  assign push   = wvalid & ~full;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    irq_d   = 1'b0;
    pop     = 1'b0;
    set_ur  = 1'b0;
    set_ab  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (cs_rise) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!empty) begin
          pop  = 1'b1;
          sh_d = mem[rptr_q[AW-1:0]];
        end else begin
          sh_d   = IDLE;
          set_ur = 1'b1;
        end
        bit_d   = '0;
        tx_d    = sh_d[0];
        busy_d  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if ((cl_rise && bit_q == LAST) || cs_fall) begin
          set_ab  = ~(cl_rise && bit_q == LAST);
          irq_d   = 1'b1;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = S_DONE;
        end else if (cl_fall) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
          tx_d  = sh_q[1];
        end
      end
      S_DONE: begin
        tx_d    = 1'b1;
        state_d = cs_s2_q ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        tx_d = 1'b1;
        if (!cs_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ur_d = clr ? 1'b0 : ur_q;
    ab_d = clr ? 1'b0 : ab_q;
    if (set_ur) ur_d = 1'b1;
    if (set_ab) ab_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      ur_q    <= 1'b0;
      ab_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      ur_q    <= ur_d;
      ab_q    <= ab_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign irq      = irq_q;
  assign underrun = ur_q;
  assign aborted  = ab_q;

endmodule

// File: tb/tb_sser_resp_tx.sv
// Directed bench for sser_resp_tx: frames driven on cs/cl with tx sampled on each cl rise.
module tb_sser_resp_tx;

  logic       clk = 1'b0;
  logic       rstb;
  logic [7:0] wdata;
  logic       wvalid, wready, cs, cl, tx, busy, irq, underrun, aborted, clr;
  logic [2:0] count;

  int compared   = 0;
  int mismatched = 0;
  int irq_cnt    = 0;
  int irq_base;
  logic [7:0] word;

  sser_resp_tx #(.DW(8), .AW(2), .IDLE(8'hFF)) dut (
    .clk(clk), .rstb(rstb), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .cs(cs), .cl(cl), .tx(tx), .count(count), .busy(busy), .irq(irq),
    .underrun(underrun), .aborted(aborted), .clr(clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq) irq_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wdata  = d;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Raises cs; optionally pushes during the LOAD cycle (3 clk after cs rises).
  task automatic frame_start(input bit do_push, input logic [7:0] pd);
    @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    if (do_push) begin
      wdata  = pd;
      wvalid = 1'b1;
      check("s5_cnt_pre", 32'(count), 32'd2);
    end
    @(negedge clk);
    wvalid = 1'b0;
    if (do_push) check("s5_cnt_post", 32'(count), 32'd2);
    repeat (2) @(negedge clk);
  endtask

  task automatic shift_bits(input int n, output logic [7:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      cl   = 1'b1;
      w[i] = tx;
      repeat (4) @(negedge clk);
      cl = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame_end();
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame(input bit do_push, input logic [7:0] pd, output logic [7:0] w);
    frame_start(do_push, pd);
    shift_bits(8, w);
    frame_end();
  endtask

  initial begin
    rstb = 1'b0; wdata = '0; wvalid = 1'b0; cs = 1'b0; cl = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single word A5
    push(8'hA5);
    check("s1_cnt1", 32'(count), 32'd1);
    irq_base = irq_cnt;
    frame_start(1'b0, 8'h00);
    check("s1_busy", 32'(busy), 32'd1);
    shift_bits(8, word);
    frame_end();
    check("s1_word", 32'(word), 32'hA5);
    check("s1_irq", 32'(irq_cnt - irq_base), 32'd1);
    check("s1_cnt0", 32'(count), 32'd0);
    check("s1_underrun", 32'(underrun), 32'd0);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_tx_idle", 32'(tx), 32'd1);

    // 2: empty FIFO -> IDLE word, sticky underrun
    frame(1'b0, 8'h00, word);
    check("s2_word", 32'(word), 32'hFF);
    check("s2_underrun", 32'(underrun), 32'd1);
    repeat (10) @(negedge clk);
    check("s2_sticky", 32'(underrun), 32'd1);
    pulse_clr();
    check("s2_clr", 32'(underrun), 32'd0);

    // 3: overfill then drain in order
    for (int i = 1; i <= 5; i++) begin
      push(8'(i));
      if (i == 4) check("s3_wready_full", 32'(wready), 32'd0);
    end
    check("s3_cnt4", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      frame(1'b0, 8'h00, word);
      check($sformatf("s3_word%0d", i), 32'(word), 32'(i));
    end
    check("s3_cnt0", 32'(count), 32'd0);
    check("s3_underrun", 32'(underrun), 32'd0);

    // 4: abort after 3 bits
    push(8'h3C);
    irq_base = irq_cnt;
    frame_start(1'b0, 8'h00);
    shift_bits(3, word);
    frame_end();
    check("s4_bits", 32'(word), 32'h04);
    check("s4_aborted", 32'(aborted), 32'd1);
    check("s4_irq", 32'(irq_cnt - irq_base), 32'd1);
    check("s4_cnt", 32'(count), 32'd0);
    frame(1'b0, 8'h00, word);
    check("s4_next_word", 32'(word), 32'hFF);
    check("s4_underrun", 32'(underrun), 32'd1);
    check("s4_aborted_sticky", 32'(aborted), 32'd1);
    pulse_clr();
    check("s4_clr_ab", 32'(aborted), 32'd0);
    check("s4_clr_ur", 32'(underrun), 32'd0);

    // 5: push and pop in one clk at count 2; pointers wrap past 8
    push(8'h11);
    push(8'h22);
    frame(1'b1, 8'h33, word);
    check("s5_word1", 32'(word), 32'h11);
    check("s5_cnt_after", 32'(count), 32'd2);
    frame(1'b0, 8'h00, word);
    check("s5_word2", 32'(word), 32'h22);
    frame(1'b0, 8'h00, word);
    check("s5_word3", 32'(word), 32'h33);
    check("s5_cnt0", 32'(count), 32'd0);

    // 6: reset mid-shift
    push(8'h5A);
    frame_start(1'b0, 8'h00);
    shift_bits(4, word);
    check("s6_partial", 32'(word), 32'h0A);
    @(negedge clk);
    rstb = 1'b0;
    cs   = 1'b0;
    #1;
    check("s6_tx", 32'(tx), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_cnt", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    frame(1'b0, 8'h00, word);
    check("s6_word", 32'(word), 32'hFF);
    check("s6_underrun", 32'(underrun), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
